// File: rtl/ysyx_24080006_axi_irom.sv
// AXI4 read-only instruction ROM slave with programmable first-beat latency.
// Supports FIXED/INCR/WRAP bursts and a side port for preloading the image.
module ysyx_24080006_axi_irom #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter int          ID_W        = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            arvalid,
    output logic            arready,
    input  logic [31:0]     araddr,
    input  logic [ID_W-1:0] arid,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    output logic            rvalid,
    input  logic            rready,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic [ID_W-1:0] rid,
    input  logic            init_we,
    input  logic [31:0]     init_addr,
    input  logic [31:0]     init_data
);

    localparam int          IDXW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAT,
        S_DATA
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic            r_arready;
    logic            r_rvalid;
    logic            r_rlast;
    logic [1:0]      r_rresp;
    logic [31:0]     r_rdata;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_addr;
    logic [7:0]      r_len;
    logic [7:0]      r_beats;
    logic [7:0]      r_lat;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_idle;
    logic            w_hs;
    logic            w_first;
    logic            w_next;
    logic            w_done;
    logic            w_load;
    logic [31:0]     w_src_addr;
    logic [7:0]      w_src_len;
    logic [7:0]      w_src_beats;
    logic [2:0]      w_src_size;
    logic [1:0]      w_src_burst;
    logic [31:0]     w_off;
    logic            w_in_rng;
    logic [IDXW-1:0] w_idx;
    logic            w_bad_len;
    logic            w_slverr;
    logic [31:0]     w_mask;
    logic [31:0]     w_addr_nx;
    logic [31:0]     w_init_off;
    logic            w_init_rng;

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;
    assign rid     = r_rid;

    assign w_idle  = (r_state == S_IDLE);
    assign w_hs    = w_idle && r_arready && arvalid;
    assign w_first = (LATENCY == 1) ? w_hs
                   : ((r_state == S_LAT) && (r_lat == 8'd1));
    assign w_next  = (r_state == S_DATA) && r_rvalid && rready && !r_rlast;
    assign w_done  = (r_state == S_DATA) && r_rvalid && rready && r_rlast;
    assign w_load  = w_first || w_next;

    // With single-cycle latency the first beat is built straight from AR.
    assign w_src_addr  = w_idle ? (araddr & 32'hFFFF_FFFC) : r_addr;
    assign w_src_len   = w_idle ? arlen   : r_len;
    assign w_src_beats = w_idle ? arlen   : r_beats;
    assign w_src_size  = w_idle ? arsize  : r_size;
    assign w_src_burst = w_idle ? arburst : r_burst;

    assign w_off    = w_src_addr - BASE_ADDR;
    assign w_in_rng = (w_off < SPAN);
    assign w_idx    = w_off[IDXW+1:2];

    assign w_bad_len = !((w_src_len == 8'd1) || (w_src_len == 8'd3) ||
                         (w_src_len == 8'd7) || (w_src_len == 8'd15));
    assign w_slverr  = (w_src_size != 3'b010) || (w_src_burst == 2'b11) ||
                       ((w_src_burst == 2'b10) && w_bad_len);

    assign w_mask = {22'b0, w_src_len, 2'b11};

    always_comb begin
        w_addr_nx = w_src_addr + 32'd4;
        case (w_src_burst)
            2'b00:   w_addr_nx = w_src_addr;
            2'b10:   w_addr_nx = (w_src_addr & ~w_mask) |
                                 ((w_src_addr + 32'd4) & w_mask);
            default: w_addr_nx = w_src_addr + 32'd4;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nx = (LATENCY == 1) ? S_DATA : S_LAT;
            S_LAT:   if (w_first) w_state_nx = S_DATA;
            S_DATA:  if (w_done) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= 32'd0;
            r_rid     <= '0;
            r_addr    <= 32'd0;
            r_len     <= 8'd0;
            r_beats   <= 8'd0;
            r_lat     <= 8'd0;
            r_size    <= 3'd0;
            r_burst   <= 2'd0;
        end else begin
            r_arready <= (w_state_nx == S_IDLE);
            if (w_hs) begin
                r_rid   <= arid;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_addr  <= araddr & 32'hFFFF_FFFC;
                r_beats <= arlen;
                r_lat   <= 8'(LATENCY - 1);
            end
            if (r_state == S_LAT) r_lat <= r_lat - 8'd1;
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rlast  <= (w_src_beats == 8'd0);
                r_addr   <= w_addr_nx;
                if (w_src_beats != 8'd0) r_beats <= w_src_beats - 8'd1;
                else                     r_beats <= 8'd0;
                if (w_slverr) begin
                    r_rresp <= 2'b10;
                    r_rdata <= 32'd0;
                end else if (!w_in_rng) begin
                    r_rresp <= 2'b11;
                    r_rdata <= 32'd0;
                end else begin
                    r_rresp <= 2'b00;
                    r_rdata <= r_mem[w_idx];
                end
            end
            if (w_done) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    assign w_init_off = init_addr - BASE_ADDR;
    assign w_init_rng = (w_init_off < SPAN);

    // A beat loaded in the same cycle as a preload write sees the old word.
    always_ff @(posedge clock) begin
        if (init_we && w_init_rng) r_mem[w_init_off[IDXW+1:2]] <= init_data;
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_irom.sv
// Directed scoreboard bench for the AXI instruction ROM slave.
module tb_ysyx_24080006_axi_irom;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = 32'd0;
    logic [3:0]  arid = 4'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'd1;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
    logic        init_we = 1'b0;
    logic [31:0] init_addr = 32'd0;
    logic [31:0] init_data = 32'd0;

    ysyx_24080006_axi_irom dut (
        .clock(clock), .reset(reset),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        logic [3:0]  id;
    } beat_t;

    beat_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int lat;

    localparam logic [31:0] W0 = 32'h0000_0413;
    localparam logic [31:0] W1 = 32'h0000_0513;
    localparam logic [31:0] W2 = 32'hA0B0_C0D2;
    localparam logic [31:0] W3 = 32'hA0B0_C0D3;
    localparam logic [31:0] WT = 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] r,
                        input logic l, input logic [3:0] id);
        q.push_back({d, r, l, id});
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        init_we = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clock);
        init_we = 1'b0;
    endtask

    task automatic ar(input logic [31:0] a, input logic [3:0] id,
                      input logic [7:0] len, input logic [2:0] sz,
                      input logic [1:0] bt);
        int t;
        @(negedge clock);
        arvalid = 1'b1;
        araddr = a;
        arid = id;
        arlen = len;
        arsize = sz;
        arburst = bt;
        t = 0;
        while (!arready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!arready) chk("ar_timeout", {31'b0, arready}, 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic collect(input int n, input logic [15:0] pat,
                           input int plen, output int lt);
        int got, t, pi;
        logic held, prev_acc;
        beat_t sv, e;
        got = 0; t = 0; pi = 0;
        held = 1'b0; prev_acc = 1'b0;
        lt = -1;
        while (got < n && t < 200) begin
            if (rvalid && lt < 0) lt = t + 1;
            if (prev_acc && !rvalid) chk("bubble", {31'b0, rvalid}, 32'd1);
            if (held) begin
                chk("hold_valid", {31'b0, rvalid}, 32'd1);
                chk("hold_data", rdata, sv.d);
                chk("hold_meta", {25'b0, rresp, rlast, rid},
                    {25'b0, sv.r, sv.l, sv.id});
            end
            if (rvalid) begin
                rready = pat[pi % plen];
                pi++;
            end else begin
                rready = 1'b1;
            end
            held = rvalid && !rready;
            if (held) sv = {rdata, rresp, rlast, rid};
            prev_acc = 1'b0;
            if (rvalid && rready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {31'b0, rvalid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("rresp", {30'b0, rresp}, {30'b0, e.r});
                    chk("rlast", {31'b0, rlast}, {31'b0, e.l});
                    chk("rid", {28'b0, rid}, {28'b0, e.id});
                end
                got++;
                prev_acc = (got < n);
            end
            t++;
            if (got < n) @(negedge clock);
        end
        if (got < n) chk("r_timeout", got, n);
    endtask

    task automatic post();
        @(negedge clock);
        chk("idle_rvalid", {31'b0, rvalid}, 32'd0);
        chk("idle_arready", {31'b0, arready}, 32'd1);
        chk("sb_empty", q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rlast", {31'b0, rlast}, 32'd0);
        chk("rst_rresp", {30'b0, rresp}, 32'd0);
        chk("rst_rid", {28'b0, rid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("arready_after_rst", {31'b0, arready}, 32'd1);

        load(32'h3000_0000, W0);
        load(32'h3000_0004, W1);
        load(32'h3000_0008, W2);
        load(32'h3000_000C, W3);
        load(32'h3000_3FFC, WT);
        load(32'h3000_4000, 32'hBAD0_BAD0);
        load(32'h2FFF_FFFC, 32'hBAD1_BAD1);

        push(W1, 2'b00, 1'b1, 4'd5);
        ar(32'h3000_0004, 4'd5, 8'd0, 3'd2, 2'b01);
        chk("lat_rvalid", {31'b0, rvalid}, 32'd0);
        chk("lat_arready", {31'b0, arready}, 32'd0);
        collect(1, 16'hFFFF, 1, lat);
        chk("latency", lat, 32'd2);
        post();

        push(W0, 2'b00, 1'b0, 4'd3);
        push(W1, 2'b00, 1'b0, 4'd3);
        push(W2, 2'b00, 1'b0, 4'd3);
        push(W3, 2'b00, 1'b1, 4'd3);
        ar(32'h3000_0000, 4'd3, 8'd3, 3'd2, 2'b01);
        collect(4, 16'h002D, 6, lat);
        post();

        push(W2, 2'b00, 1'b0, 4'd6);
        push(W3, 2'b00, 1'b0, 4'd6);
        push(W0, 2'b00, 1'b0, 4'd6);
        push(W1, 2'b00, 1'b1, 4'd6);
        ar(32'h3000_0008, 4'd6, 8'd3, 3'd2, 2'b10);
        collect(4, 16'hFFFF, 1, lat);
        post();

        push(WT, 2'b00, 1'b0, 4'd1);
        push(32'd0, 2'b11, 1'b1, 4'd1);
        ar(32'h3000_3FFC, 4'd1, 8'd1, 3'd2, 2'b01);
        collect(2, 16'hFFFF, 1, lat);
        post();

        push(32'd0, 2'b11, 1'b1, 4'd2);
        ar(32'h2FFF_FFFC, 4'd2, 8'd0, 3'd2, 2'b01);
        collect(1, 16'hFFFF, 1, lat);
        post();

        push(32'd0, 2'b10, 1'b0, 4'd7);
        push(32'd0, 2'b10, 1'b1, 4'd7);
        ar(32'h3000_0000, 4'd7, 8'd1, 3'd1, 2'b01);
        collect(2, 16'hFFFF, 1, lat);
        post();

        push(32'd0, 2'b10, 1'b0, 4'd8);
        push(32'd0, 2'b10, 1'b0, 4'd8);
        push(32'd0, 2'b10, 1'b1, 4'd8);
        ar(32'h3000_0000, 4'd8, 8'd2, 3'd2, 2'b10);
        collect(3, 16'hFFFF, 1, lat);
        post();

        push(W1, 2'b00, 1'b0, 4'd4);
        push(W1, 2'b00, 1'b0, 4'd4);
        push(W1, 2'b00, 1'b1, 4'd4);
        ar(32'h3000_0004, 4'd4, 8'd2, 3'd2, 2'b00);
        collect(3, 16'h0005, 3, lat);
        post();

        push(32'd0, 2'b10, 1'b1, 4'd11);
        ar(32'h3000_0000, 4'd11, 8'd0, 3'd2, 2'b11);
        collect(1, 16'hFFFF, 1, lat);
        post();

        push(W0, 2'b00, 1'b0, 4'd9);
        push(W1, 2'b00, 1'b0, 4'd9);
        ar(32'h3000_0000, 4'd9, 8'd7, 3'd2, 2'b01);
        collect(2, 16'hFFFF, 1, lat);
        @(negedge clock);
        chk("beat2_valid", {31'b0, rvalid}, 32'd1);
        chk("beat2_data", rdata, W2);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("midrst_arready", {31'b0, arready}, 32'd0);
        chk("midrst_rlast", {31'b0, rlast}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("postrst_rvalid", {31'b0, rvalid}, 32'd0);
        end
        push(W3, 2'b00, 1'b1, 4'd10);
        ar(32'h3000_000C, 4'd10, 8'd0, 3'd2, 2'b01);
        collect(1, 16'hFFFF, 1, lat);
        chk("latency_after_rst", lat, 32'd2);
        post();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
